// File: rtl/ssd_bin_to_bcd.sv
// Sequential double-dabble converter: binary SSD value -> packed BCD digits.
// One input bit is consumed per cycle. A guard digit above the displayed
// digits detects overflow, and an overflowing result saturates to all nines.
module ssd_bin_to_bcd #(
    parameter int unsigned BIN_W  = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SCR_W = BCD_W + 4;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   adj;
    logic               ready_d;
    logic               done_d;
    logic [BCD_W-1:0]   bcd_d;
    logic               ovf_d;

    // Add 3 to every scratch digit that is 5 or more, ahead of the shift
    function automatic logic [SCR_W-1:0] dabble(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        r = s;
        for (int unsigned i = 0; i < SCR_W / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        bcd_d   = bcd_o;
        ovf_d   = ovf_o;
        ready_d = 1'b0;
        adj     = dabble(scr_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {adj[SCR_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (scr_q[SCR_W-1 -: 4] != 4'd0) begin
                    ovf_d = 1'b1;
                    bcd_d = {DIGITS{4'h9}};
                end else begin
                    ovf_d = 1'b0;
                    bcd_d = scr_q[BCD_W-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
            bcd_o   <= '0;
            ovf_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            ready_o <= ready_d;
            done_o  <= done_d;
            bcd_o   <= bcd_d;
            ovf_o   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ssd_bin_to_bcd.sv
// Scoreboard bench for ssd_bin_to_bcd: a 13-bit instance and a 14-bit instance
// (the 14-bit one can overflow four digits). Expected results come from
// decimal arithmetic on the input value.
module tb_ssd_bin_to_bcd;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, startw;
    logic [12:0] bin;
    logic [13:0] binw;
    logic        rdy, done, ovf, rdyw, donew, ovfw;
    logic [15:0] bcd, bcdw;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t qn[$];
    exp_t qw[$];
    exp_t en, ew;
    logic [15:0] pb = 16'h0, pbw = 16'h0;
    logic        po = 1'b0, pow = 1'b0, pd = 1'b0, pdw = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ssd_bin_to_bcd #(.BIN_W(13), .DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(bin),
        .ready_o(rdy), .done_o(done), .bcd_o(bcd), .ovf_o(ovf)
    );

    ssd_bin_to_bcd #(.BIN_W(14), .DIGITS(4)) dutw (
        .clk(clk), .rst_n(rst_n), .start_i(startw), .bin_i(binw),
        .ready_o(rdyw), .done_o(donew), .bcd_o(bcdw), .ovf_o(ovfw)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal reference: digits by division, saturate above 9999
    task automatic model(input int unsigned v, output logic [15:0] b, output logic o);
        if (v > 9999) begin
            o = 1'b1;
            b = 16'h9999;
        end else begin
            o = 1'b0;
            b = 16'h0;
            for (int d = 0; d < 4; d++) begin
                b[4*d +: 4] = 4'((v / (10 ** d)) % 10);
            end
        end
    endtask

    task automatic issue(input bit wide, input int unsigned v, input bit noise);
        exp_t e;
        int n;
        n = 0;
        while ((wide ? rdyw : rdy) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready got 0 expected 1 after %0d cycles", n);
            return;
        end
        model(v, e.bcd, e.ovf);
        e.acc = cyc + 1;
        if (wide) begin
            startw = 1'b1;
            binw = 14'(v);
            qw.push_back(e);
        end else begin
            start = 1'b1;
            bin = 13'(v);
            qn.push_back(e);
        end
        @(negedge clk);
        if (wide) chk("wide_busy_ready", 32'(rdyw), 32'd0);
        else      chk("narrow_busy_ready", 32'(rdy), 32'd0);
        n = 0;
        while ((wide ? rdyw : rdy) !== 1'b1 && n < 100) begin
            if (wide) begin
                startw = noise ? 1'($urandom) : 1'b0;
                binw = 14'($urandom);
            end else begin
                start = noise ? 1'($urandom) : 1'b0;
                bin = 13'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: ready got 0 expected 1 after %0d cycles", n);
        end
        start = 1'b0;
        startw = 1'b0;
    endtask

    // Monitor for the 13-bit instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                chk("narrow_done_width", 32'(pd), 32'd0);
                chk("narrow_ready_at_done", 32'(rdy), 32'd1);
                if (qn.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL narrow_unexpected_done: got done=1 expected done=0 bcd=0x%0h", bcd);
                end else begin
                    en = qn.pop_front();
                    chk("narrow_bcd", 32'(bcd), 32'(en.bcd));
                    chk("narrow_ovf", 32'(ovf), 32'(en.ovf));
                    chk("narrow_latency", 32'(cyc - en.acc), 32'd14);
                end
            end else begin
                chk("narrow_hold", {15'b0, ovf, bcd}, {15'b0, po, pb});
            end
        end
        pb = bcd;
        po = ovf;
        pd = done;
    end

    // Monitor for the 14-bit instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (donew) begin
                chk("wide_done_width", 32'(pdw), 32'd0);
                if (qw.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wide_unexpected_done: got done=1 expected done=0 bcd=0x%0h", bcdw);
                end else begin
                    ew = qw.pop_front();
                    chk("wide_bcd", 32'(bcdw), 32'(ew.bcd));
                    chk("wide_ovf", 32'(ovfw), 32'(ew.ovf));
                    chk("wide_latency", 32'(cyc - ew.acc), 32'd15);
                end
            end else begin
                chk("wide_hold", {15'b0, ovfw, bcdw}, {15'b0, pow, pbw});
            end
        end
        pbw = bcdw;
        pow = ovfw;
        pdw = donew;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start = 1'b0;
        startw = 1'b0;
        bin = '0;
        binw = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(rdy), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_ready_wide", 32'(rdyw), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 0, 0);
        issue(0, 1234, 0);
        issue(0, 8191, 0);
        issue(0, 4321, 1);

        // Abort a conversion of 777 with an asynchronous reset mid-shift
        start = 1'b1;
        bin = 13'd777;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy), 32'd1);
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(0, 55, 0);

        for (int v = 0; v < 8192; v += 41) issue(0, v, 0);
        issue(0, 8190, 0);
        issue(0, 9, 1);
        for (int i = 0; i < 200; i++) issue(0, $urandom_range(0, 8191), 1'($urandom));

        issue(1, 16383, 0);
        issue(1, 9999, 0);
        issue(1, 10000, 0);
        issue(1, 0, 0);
        for (int i = 0; i < 50; i++) issue(1, $urandom_range(0, 16383), 1'($urandom));

        n = 0;
        while ((qn.size() != 0 || qw.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qn.size() != 0 || qw.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d pending results expected 0", qn.size(), qw.size());
        end
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
